pixel_window_fetch: RTL and testbench
=====================================

# pixel_window_fetch

Memory-side sequencer that consumes the addresses produced by the edge-detection address counter. For every 3x3 window it requests nine read addresses, performs nine single-pixel memory reads, presents the assembled window to the convolution datapath, then requests one write address and writes the filtered result back. It sits between the address counter, the shared pixel memory port and the gradient compute block, and owns the pacing of the whole image pass.

## Interface
- PIXEL_W, 8, bits per pixel (memory data width)
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- i_start  in  1  one-cycle pulse; begin an image pass (ignored unless idle)
- i_num_windows  in  32  window count, (width-2)*(height-2); latched on accepted i_start
- o_inc_raddr  out  1  one-cycle pulse requesting next read address
- i_raddr  in  32  read address, valid when i_r_ready=1
- i_r_ready  in  1  one-cycle pulse; i_raddr valid
- o_inc_waddr  out  1  one-cycle pulse requesting next write address
- i_waddr  in  32  write address, valid when i_w_ready=1
- i_w_ready  in  1  one-cycle pulse; i_waddr valid
- o_mem_addr  out  32  memory address
- o_mem_read  out  1  read request, held until accepted
- o_mem_write  out  1  write request, held until accepted
- o_mem_wdata  out  PIXEL_W  write data
- i_mem_rdata  in  PIXEL_W  read data, valid in the accept cycle
- i_mem_busy  in  1  memory stall; a request is accepted in a cycle where it is asserted and i_mem_busy=0
- o_window  out  9*PIXEL_W  pixel k (row-major, k=0..8) at bits [k*PIXEL_W +: PIXEL_W]
- o_window_valid  out  1  window stable and valid, level
- i_result  in  PIXEL_W  filtered pixel
- i_result_valid  in  1  result strobe, sampled only while o_window_valid=1
- o_busy  out  1  high from accepted i_start until o_done
- o_done  out  1  one-cycle pulse after last write accepted

## Operation
- States: IDLE, REQ_RADDR, WAIT_RADDR, MEM_READ, WINDOW_OUT, REQ_WADDR, WAIT_WADDR, MEM_WRITE, DONE.
- IDLE: on i_start latch i_num_windows into N, clear pixel index k and window count w; N=0 -> DONE, else REQ_RADDR.
- REQ_RADDR: o_inc_raddr=1 for this cycle only -> WAIT_RADDR.
- WAIT_RADDR: on i_r_ready latch i_raddr -> MEM_READ; otherwise wait indefinitely.
- MEM_READ: o_mem_read=1, o_mem_addr=latched raddr. On accept store i_mem_rdata into slot k; k=8 -> k=0, WINDOW_OUT; else k+1, REQ_RADDR.
- WINDOW_OUT: o_window_valid=1; on i_result_valid latch i_result into wdata -> REQ_WADDR.
- REQ_WADDR: o_inc_waddr=1 one cycle -> WAIT_WADDR; on i_w_ready latch i_waddr -> MEM_WRITE.
- MEM_WRITE: o_mem_write=1, o_mem_addr=latched waddr, o_mem_wdata=result. On accept: w=N-1 -> DONE, else w+1, REQ_RADDR.
- DONE: o_done=1 for one cycle -> IDLE.
- o_mem_read and o_mem_write never both high; o_mem_addr/wdata stable while request held.
- o_window holds last window contents outside WINDOW_OUT; slots update only on read accept.
- Counters: k 4-bit, w and N 32-bit unsigned; no wrap beyond N.

## Timing
- Reset values: all outputs 0 (o_window, o_mem_addr, o_mem_wdata all zeros), state IDLE, k=w=N=0, latched addresses 0.
- All outputs registered or decoded from state only; no combinational path from any input to any output.
- i_start to first o_inc_raddr: 1 cycle (pulse in cycle after i_start sampled).
- i_r_ready to o_mem_read high: 1 cycle; with i_mem_busy=0 each read occupies exactly 1 cycle.
- Per window, zero stall, address latency L cycles (inc pulse to ready): 9*(L+2) + 1 + (result wait) + (L+2) cycles.
- i_r_ready/i_w_ready outside their WAIT state: ignored. i_result_valid outside WINDOW_OUT: ignored. i_start while o_busy: ignored.
- i_mem_busy held high: request and address held unchanged, no timeout.
- rst asserted mid-pass: all outputs (including o_mem_read/o_mem_write) drop immediately, state IDLE; no partial write completes.
- o_busy falls in the DONE cycle as o_done rises.

## Test plan
- Reset: assert rst mid-MEM_READ with i_mem_busy=1 -> o_mem_read=0, o_busy=0 same cycle; all outputs 0; returns to IDLE.
- Single window: N=1, address model L=4 returning 100..108, memory returns data=addr[7:0] -> o_window pixels 100..108 in slots 0..8; i_result=0x5A -> write at supplied waddr 500 with data 0x5A; o_done pulse 1 cycle after write accept.
- Back-to-back windows: N=4 -> exactly 36 o_inc_raddr pulses, 4 o_inc_waddr pulses, 4 writes, one o_done.
- Memory stall: i_mem_busy=1 for 5 cycles on read 3 -> o_mem_read and o_mem_addr held constant 6 cycles, pixel captured only on accept, slot order unchanged.
- Spurious strobes: i_r_ready during MEM_READ, i_result_valid before WINDOW_OUT, i_start while busy -> no state change, no extra requests.
- N=0: i_start -> o_done pulse 2 cycles later, no o_inc_raddr, no memory access.

Source files
------------

// File: rtl/pixel_window_fetch.sv
// Memory-side sequencer for the 3x3 edge-detection pass: fetches nine pixels per window,
// presents the window to the gradient block, then writes the filtered pixel back.
module pixel_window_fetch #(
  parameter int PIXEL_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [31:0]          i_num_windows,
  output logic                 o_inc_raddr,
  input  logic [31:0]          i_raddr,
  input  logic                 i_r_ready,
  output logic                 o_inc_waddr,
  input  logic [31:0]          i_waddr,
  input  logic                 i_w_ready,
  output logic [31:0]          o_mem_addr,
  output logic                 o_mem_read,
  output logic                 o_mem_write,
  output logic [PIXEL_W-1:0]   o_mem_wdata,
  input  logic [PIXEL_W-1:0]   i_mem_rdata,
  input  logic                 i_mem_busy,
  output logic [9*PIXEL_W-1:0] o_window,
  output logic                 o_window_valid,
  input  logic [PIXEL_W-1:0]   i_result,
  input  logic                 i_result_valid,
  output logic                 o_busy,
  output logic                 o_done
);

  typedef enum logic [3:0] {
    IDLE,
    REQ_RADDR,
    WAIT_RADDR,
    MEM_READ,
    WINDOW_OUT,
    REQ_WADDR,
    WAIT_WADDR,
    MEM_WRITE,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        n_q, n_d;
  logic [31:0]        w_q, w_d;
  logic [3:0]         k_q, k_d;
  logic [31:0]        raddr_q, raddr_d;
  logic [31:0]        waddr_q, waddr_d;
  logic [PIXEL_W-1:0] result_q, result_d;
  logic [PIXEL_W-1:0] win_q [9];
  logic               win_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      n_q      <= '0;
      w_q      <= '0;
      k_q      <= '0;
      raddr_q  <= '0;
      waddr_q  <= '0;
      result_q <= '0;
      for (int i = 0; i < 9; i++) win_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      w_q      <= w_d;
      k_q      <= k_d;
      raddr_q  <= raddr_d;
      waddr_q  <= waddr_d;
      result_q <= result_d;
      // Slots change only on an accepted read, so the window holds between passes.
      if (win_we) win_q[k_q] <= i_mem_rdata;
    end
  end

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    w_d      = w_q;
    k_d      = k_q;
    raddr_d  = raddr_q;
    waddr_d  = waddr_q;
    result_d = result_q;
    win_we   = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          n_d     = i_num_windows;
          k_d     = '0;
          w_d     = '0;
          state_d = (i_num_windows == 32'd0) ? DONE : REQ_RADDR;
        end
      end
      REQ_RADDR: state_d = WAIT_RADDR;
      WAIT_RADDR: begin
        if (i_r_ready) begin
          raddr_d = i_raddr;
          state_d = MEM_READ;
        end
      end
      MEM_READ: begin
        if (!i_mem_busy) begin
          win_we = 1'b1;
          if (k_q == 4'd8) begin
            k_d     = '0;
            state_d = WINDOW_OUT;
          end else begin
            k_d     = k_q + 4'd1;
            state_d = REQ_RADDR;
          end
        end
      end
      WINDOW_OUT: begin
        if (i_result_valid) begin
          result_d = i_result;
          state_d  = REQ_WADDR;
        end
      end
      REQ_WADDR: state_d = WAIT_WADDR;
      WAIT_WADDR: begin
        if (i_w_ready) begin
          waddr_d = i_waddr;
          state_d = MEM_WRITE;
        end
      end
      MEM_WRITE: begin
        if (!i_mem_busy) begin
          if (w_q == n_q - 32'd1) begin
            state_d = DONE;
          end else begin
            w_d     = w_q + 32'd1;
            state_d = REQ_RADDR;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode the state register and latched values only, so reset clears them at once.
  always_comb begin
    o_inc_raddr    = (state_q == REQ_RADDR);
    o_inc_waddr    = (state_q == REQ_WADDR);
    o_mem_read     = (state_q == MEM_READ);
    o_mem_write    = (state_q == MEM_WRITE);
    o_window_valid = (state_q == WINDOW_OUT);
    o_done         = (state_q == DONE);
    o_busy         = (state_q != IDLE) && (state_q != DONE);
    o_mem_addr     = '0;
    o_mem_wdata    = '0;
    if (state_q == MEM_READ) o_mem_addr = raddr_q;
    if (state_q == MEM_WRITE) begin
      o_mem_addr  = waddr_q;
      o_mem_wdata = result_q;
    end
    o_window = '0;
    for (int i = 0; i < 9; i++) o_window[i*PIXEL_W +: PIXEL_W] = win_q[i];
  end

endmodule

// File: tb/tb_pixel_window_fetch.sv
// Randomized bench for pixel_window_fetch: address counters, memory and gradient block are
// modelled as transaction queues; reads, windows and writes are compared against them.
module tb_pixel_window_fetch;
  localparam int PIXEL_W = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 i_start;
  logic [31:0]          i_num_windows;
  logic                 o_inc_raddr;
  logic [31:0]          i_raddr;
  logic                 i_r_ready;
  logic                 o_inc_waddr;
  logic [31:0]          i_waddr;
  logic                 i_w_ready;
  logic [31:0]          o_mem_addr;
  logic                 o_mem_read;
  logic                 o_mem_write;
  logic [PIXEL_W-1:0]   o_mem_wdata;
  logic [PIXEL_W-1:0]   i_mem_rdata;
  logic                 i_mem_busy;
  logic [9*PIXEL_W-1:0] o_window;
  logic                 o_window_valid;
  logic [PIXEL_W-1:0]   i_result;
  logic                 i_result_valid;
  logic                 o_busy;
  logic                 o_done;

  always #5 clk = ~clk;

  pixel_window_fetch #(.PIXEL_W(PIXEL_W)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_num_windows(i_num_windows),
    .o_inc_raddr(o_inc_raddr), .i_raddr(i_raddr), .i_r_ready(i_r_ready),
    .o_inc_waddr(o_inc_waddr), .i_waddr(i_waddr), .i_w_ready(i_w_ready),
    .o_mem_addr(o_mem_addr), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata), .i_mem_busy(i_mem_busy),
    .o_window(o_window), .o_window_valid(o_window_valid), .i_result(i_result),
    .i_result_valid(i_result_valid), .o_busy(o_busy), .o_done(o_done)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] raddr_next, waddr_next;

  function automatic logic [7:0] mem_val(input logic [31:0] a);
    return a[7:0] ^ a[15:8];
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    i_start = 0; i_num_windows = '0; i_raddr = '0; i_r_ready = 0; i_waddr = '0;
    i_w_ready = 0; i_mem_rdata = '0; i_mem_busy = 0; i_result = '0; i_result_valid = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_rd"}, o_mem_read, 0);
    check_eq({tag, "_wr"}, o_mem_write, 0);
    check_eq({tag, "_busy"}, o_busy, 0);
    check_eq({tag, "_done"}, o_done, 0);
    check_eq({tag, "_incr"}, o_inc_raddr, 0);
    check_eq({tag, "_incw"}, o_inc_waddr, 0);
    check_eq({tag, "_addr"}, o_mem_addr, 0);
    check_eq({tag, "_wdata"}, o_mem_wdata, 0);
    check_eq({tag, "_wvld"}, o_window_valid, 0);
    check_eq({tag, "_win_nz"}, (o_window != '0), 0);
  endtask

  // One image pass of n windows. fix_l=0 picks a random address latency 1..4 per request.
  // stall_rd (1-based) holds i_mem_busy for stall_len cycles on that read.
  // abort_rd>0 asserts rst while that read (0-based) is stalled and returns.
  task automatic run_pass(input int n, input int fix_l, input logic [31:0] rbase,
                          input logic [31:0] wbase, input int stall_rd, input int stall_len,
                          input bit noise, input int abort_rd, input int fix_res,
                          input int exp_lat);
    logic [31:0] rsup[$];
    logic [31:0] wsup[$];
    logic [7:0]  rexp[$];
    logic [7:0]  rv;
    logic [31:0] prev_addr;
    logic [1:0]  prev_req;
    int r_cd, w_cd, n_rinc, n_winc, n_rd, n_wr, n_done, res_wait, stall_left, stall_cyc;
    int cyc, done_cyc, budget;
    bit res_armed, res_given, prev_hold, stalled, busy_now;
    r_cd = -1; w_cd = -1; n_rinc = 0; n_winc = 0; n_rd = 0; n_wr = 0; n_done = 0;
    res_wait = 0; stall_left = 0; stall_cyc = 0; cyc = 0; done_cyc = -1;
    res_armed = 0; res_given = 0; prev_hold = 0; stalled = 0; prev_addr = '0; prev_req = '0;
    budget = 300 + 150 * n;
    raddr_next = rbase;
    waddr_next = wbase;
    @(negedge clk);
    i_start = 1; i_num_windows = n;
    while (cyc < budget) begin
      @(negedge clk);
      if (cyc == 0) begin
        check_eq("start_busy", o_busy, (n > 0));
        check_eq("start_inc", o_inc_raddr, (n > 0));
      end
      if (o_mem_read || o_mem_write) check_eq("rd_wr_excl", o_mem_read & o_mem_write, 0);
      if (prev_hold) begin
        check_eq("hold_req", {o_mem_read, o_mem_write}, prev_req);
        check_eq("hold_addr", o_mem_addr, prev_addr);
      end
      if (o_inc_raddr) n_rinc++;
      if (o_inc_waddr) n_winc++;
      if (o_done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (!o_window_valid) begin
        res_armed = 0; res_given = 0;
      end else if (!res_armed) begin
        res_armed = 1;
        res_wait = noise ? $urandom_range(0, 3) : 0;
        check_eq("win_src", rsup.size(), 9 * n_wr + 9);
        if (rsup.size() >= 9 * n_wr + 9)
          for (int k = 0; k < 9; k++)
            check_eq($sformatf("win%0d_px%0d", n_wr, k), o_window[k*8 +: 8],
                     mem_val(rsup[9*n_wr + k]));
      end

      // read-address counter model
      i_r_ready = 0; i_raddr = $urandom;
      if (r_cd == 0) begin
        i_r_ready = 1; i_raddr = raddr_next; rsup.push_back(raddr_next);
        raddr_next += noise ? $urandom_range(1, 3) : 1;
        r_cd = -1;
      end else if (r_cd > 0) r_cd--;
      else if (noise && !o_inc_raddr && $urandom_range(0, 5) == 0) i_r_ready = 1;
      if (o_inc_raddr) r_cd = (fix_l > 0 ? fix_l : $urandom_range(1, 4)) - 1;

      // write-address counter model
      i_w_ready = 0; i_waddr = $urandom;
      if (w_cd == 0) begin
        i_w_ready = 1; i_waddr = waddr_next; wsup.push_back(waddr_next);
        waddr_next += noise ? $urandom_range(1, 9) : 1;
        w_cd = -1;
      end else if (w_cd > 0) w_cd--;
      else if (noise && !o_inc_waddr && $urandom_range(0, 5) == 0) i_w_ready = 1;
      if (o_inc_waddr) w_cd = (fix_l > 0 ? fix_l : $urandom_range(1, 4)) - 1;

      // gradient block model
      i_result_valid = 0; i_result = $urandom;
      if (o_window_valid && !res_given) begin
        if (res_wait == 0) begin
          rv = (fix_res >= 0) ? fix_res[7:0] : 8'($urandom);
          i_result_valid = 1; i_result = rv; rexp.push_back(rv); res_given = 1;
        end else res_wait--;
      end else if (!o_window_valid && noise && $urandom_range(0, 5) == 0) i_result_valid = 1;

      // memory model
      busy_now = 0;
      if (o_mem_read && stall_rd > 0 && n_rd == stall_rd - 1) begin
        if (!stalled) begin stalled = 1; stall_left = stall_len; end
        stall_cyc++;
        if (stall_left > 0) begin busy_now = 1; stall_left--; end
      end else if (noise) busy_now = ($urandom_range(0, 3) == 0);
      i_mem_busy = busy_now;
      i_mem_rdata = mem_val(o_mem_addr);

      if (abort_rd > 0 && o_mem_read && n_rd == abort_rd && busy_now) begin
        #2 rst = 1;
        #1 check_all_zero("rst_mid");
        @(negedge clk);
        check_all_zero("rst_held");
        rst = 0;
        clear_inputs();
        return;
      end

      prev_hold = (o_mem_read || o_mem_write) && busy_now;
      prev_addr = o_mem_addr;
      prev_req  = {o_mem_read, o_mem_write};
      if (o_mem_read && !busy_now) begin
        check_eq("rd_supplied", (n_rd < rsup.size()), 1);
        if (n_rd < rsup.size()) check_eq("rd_addr", o_mem_addr, rsup[n_rd]);
        n_rd++;
      end
      if (o_mem_write && !busy_now) begin
        check_eq("wr_supplied", (n_wr < wsup.size() && n_wr < rexp.size()), 1);
        if (n_wr < wsup.size() && n_wr < rexp.size()) begin
          check_eq("wr_addr", o_mem_addr, wsup[n_wr]);
          check_eq("wr_data", o_mem_wdata, rexp[n_wr]);
        end
        n_wr++;
      end

      i_start = 0;
      if (noise && o_busy && $urandom_range(0, 15) == 0) begin
        i_start = 1; i_num_windows = $urandom_range(1, 7);
      end
      cyc++;
      if (done_cyc >= 0 && cyc > done_cyc + 3) break;
    end
    clear_inputs();
    check_eq("done_seen", (done_cyc >= 0), 1);
    check_eq("n_done", n_done, 1);
    check_eq("n_inc_raddr", n_rinc, 9 * n);
    check_eq("n_inc_waddr", n_winc, n);
    check_eq("n_reads", n_rd, 9 * n);
    check_eq("n_writes", n_wr, n);
    check_eq("busy_after", o_busy, 0);
    if (exp_lat >= 0) check_eq("latency", done_cyc, exp_lat);
    if (n == 0) check_eq("n0_done_by_2", (done_cyc >= 0 && done_cyc <= 1), 1);
    if (stall_rd > 0) check_eq("stall_cycles", stall_cyc, stall_len + 1);
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 0;
    @(negedge clk);
    check_all_zero("idle");

    // single window, fixed latency 4, reads 100..108, result 0x5A written at 500
    run_pass(1, 4, 32'd100, 32'd500, 0, 0, 1'b0, 0, 'h5A, 61);
    check_eq("hold_win_px0", o_window[7:0], 8'd100);
    check_eq("hold_win_px8", o_window[71:64], 8'd108);

    // back-to-back windows
    run_pass(4, 2, 32'd1000, 32'd2000, 0, 0, 1'b0, 0, -1, -1);

    // five-cycle stall on read 3
    run_pass(2, 1, 32'd300, 32'd700, 3, 5, 1'b0, 0, -1, -1);

    // randomized passes with spurious strobes, random stalls and ignored starts
    for (int p = 0; p < 4; p++)
      run_pass($urandom_range(1, 5), 0, $urandom, $urandom, 0, 0, 1'b1, 0, -1, -1);

    // empty image
    run_pass(0, 1, 32'd0, 32'd0, 0, 0, 1'b0, 0, -1, -1);

    // reset during a stalled read, then a clean pass to show recovery
    run_pass(2, 1, 32'h1234, 32'h60, 5, 100, 1'b0, 4, -1, -1);
    check_all_zero("after_rst");
    run_pass(1, 3, 32'h2200, 32'h80, 0, 0, 1'b0, 0, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
